// File: rtl/uart_tx_queue.sv
// uart_tx_queue: circular byte queue feeding a UART transmitter.
// Words are accepted from the host with a valid/ready handshake.
// Each word is launched with a single-cycle tx_start pulse.
// The next word is launched only after the transmitter's tx_done pulse.
module uart_tx_queue #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    output logic                       wr_ready,
    input  logic                       flush,
    output logic                       tx_start,
    output logic [DATA_WIDTH-1:0]      tx_data,
    input  logic                       tx_done,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [AW-1:0]           rd_ptr;
    logic [AW-1:0]           wr_ptr;
    logic [CW-1:0]           cnt;
    logic                    full;
    logic                    empty;
    logic                    wr_en;
    logic                    pop;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);

    // wr_ready depends only on the registered count, never on the pop path.
    assign wr_ready = !full;
    assign count    = cnt;

    // A coincident flush swallows the write without flagging overflow.
    assign wr_en = wr_valid && !full && !flush;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a pop happens exactly when a new frame is loaded.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !flush) begin
                    pop       = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (tx_done) begin
                    if (!empty && !flush) begin
                        pop       = 1'b1;
                        state_nxt = LOAD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Moore outputs.
    always_comb begin
        tx_start = 1'b0;
        busy     = 1'b0;
        if (state == LOAD) begin
            tx_start = 1'b1;
        end
        if ((state != IDLE) || !empty) begin
            busy = 1'b1;
        end
    end

    // Pointers and occupancy; flush empties the queue but leaves the frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Frame data register: changes only on a pop and holds across IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data <= '0;
        end else if (pop) begin
            tx_data <= mem[rd_ptr];
        end
    end

    // Sticky overflow flag: a write attempt while full, unless flushed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (wr_valid && full && !flush) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: scoreboard bench for uart_tx_queue.
// The reference model is a queue of words waiting for launch plus an in-flight flag.
module tb_uart_tx_queue;

    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_valid;
    logic [DW-1:0]   wr_data;
    logic            wr_ready;
    logic            flush;
    logic            tx_start;
    logic [DW-1:0]   tx_data;
    logic            tx_done;
    logic [4:0]      count;
    logic            overflow;
    logic            busy;

    uart_tx_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .flush    (flush),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_done  (tx_done),
        .count    (count),
        .overflow (overflow),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [DW-1:0] q[$];
    logic [DW-1:0] cur = '0;
    bit            in_flight = 0;
    bit            exp_start = 0;
    bit            exp_ovf   = 0;
    bit            flush_hit = 0;
    bit            auto_done = 1;
    int            done_lat  = 20;
    int            total = 0;
    int            bad   = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic pulse_done();
        @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
    endtask

    // Present one word (optionally with flush) for one edge; the model decides its fate.
    task automatic wr(input logic [DW-1:0] d, input bit fl);
        wr_valid = 1'b1;
        wr_data  = d;
        flush    = fl;
        @(posedge clk);
        if (fl) begin
            q.delete();
            flush_hit = 1;
        end else if (q.size() < DEPTH) begin
            q.push_back(d);
        end else begin
            exp_ovf = 1;
        end
        #1;
        wr_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || in_flight) && t < 5000) begin
            idle(1);
            t++;
        end
        total++;
        if (t >= 5000) begin
            bad++;
            $display("FAIL drain: queued=%0d in_flight=%0d required empty and idle", q.size(), in_flight);
        end
    endtask

    // Transmitter model: answers each launch with tx_done after done_lat edges.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start && auto_done && !rst) begin
                repeat (done_lat) @(posedge clk);
                #1 tx_done = 1'b1;
                @(posedge clk);
                #1 tx_done = 1'b0;
            end
        end
    end

    // Monitor: compares every observable output against the model each cycle.
    initial begin
        logic [DW-1:0] e;
        bit started;
        bit done_now;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_flight = 0;
                cur       = '0;
                exp_start = 0;
                flush_hit = 0;
                continue;
            end
            if (flush_hit) begin
                exp_start = 0;
                flush_hit = 0;
            end
            chk("tx_start", tx_start, exp_start);
            started = 0;
            if (tx_start) begin
                started = 1;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL launch_order: tx_start with tx_data=%0h, required no launch (queue empty)", tx_data);
                end else begin
                    e = q.pop_front();
                    chk("tx_data_launch", tx_data, e);
                    cur = e;
                end
                in_flight = 1;
            end else begin
                chk("tx_data_hold", tx_data, cur);
            end
            chk("count", count, q.size());
            chk("wr_ready", wr_ready, (q.size() < DEPTH) ? 1 : 0);
            chk("overflow", overflow, exp_ovf);
            chk("busy", busy, (in_flight || q.size() != 0) ? 1 : 0);
            done_now  = tx_done && in_flight && !started;
            exp_start = (q.size() != 0) && (!in_flight || done_now);
            if (done_now) in_flight = 0;
        end
    end

    // Watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // Stimulus.
    initial begin
        int sent;
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_data  = '0;
        flush    = 1'b0;
        tx_done  = 1'b0;
        #1;
        chk("rst_tx_start", tx_start, 0);
        chk("rst_count", count, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_tx_data", tx_data, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single word, empty-queue latency.
        done_lat = 20;
        wr(8'hA5, 0);
        drain();
        idle(3);

        // Three back-to-back words, transmitter answering after 20 cycles.
        wr(8'h01, 0);
        wr(8'h02, 0);
        wr(8'h03, 0);
        drain();
        idle(3);

        // Pointer wrap: 40 random words, queue kept below full.
        done_lat = 3;
        sent = 0;
        while (sent < 40) begin
            if (q.size() < 15 && $urandom_range(0, 2) != 0) begin
                wr(DW'($urandom), 0);
                sent++;
            end else begin
                idle(1);
            end
        end
        drain();
        idle(3);

        // Flush with a coincident write while 0x10 is in flight.
        done_lat = 40;
        wr(8'h10, 0);
        for (int i = 0; i < 5; i++) wr(DW'(8'h20 + i), 0);
        wr(8'h77, 1);
        drain();
        idle(5);

        // Fill to full with no tx_done, then overflow, then release one frame.
        auto_done = 0;
        for (int i = 0; i < 18; i++) wr(DW'(i), 0);
        idle(3);
        chk("ovf_sticky", overflow, 1);
        auto_done = 1;
        done_lat  = 4;
        pulse_done();
        drain();
        idle(3);

        // Asynchronous reset while waiting for tx_done with 3 words queued.
        done_lat = 30;
        for (int i = 0; i < 4; i++) wr(DW'(8'hC0 + i), 0);
        idle(8);
        @(posedge clk);
        #3 rst = 1'b1;
        q.delete();
        exp_ovf = 0;
        #1;
        chk("arst_tx_start", tx_start, 0);
        chk("arst_count", count, 0);
        chk("arst_wr_ready", wr_ready, 1);
        chk("arst_busy", busy, 0);
        chk("arst_overflow", overflow, 0);
        chk("arst_tx_data", tx_data, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
